pri_arb: RTL and testbench

PRI_ARB -- requirements
Module: pri_arb

---
 rtl/pri_pkg.sv | 12 +
 rtl/pri_find.sv | 30 +++
 rtl/pri_arb.sv | 82 ++++++++
 tb/tb_pri_arb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// Shared types and constants for the priority / round-robin arbiter.
package pri_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : pri_pkg

// File: rtl/pri_find.sv
// Combinational search: scan downward from start (wrapping N-1..0), first set request wins.
module pri_find #(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found_c,
    output logic [N-1:0] onehot_c,
    output logic [W-1:0] idx_c
);

    logic [W-1:0] pos;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found_c  = 1'b0;
        idx_c    = '0;
        pos      = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = W'((int'(start) + int'(N) - k) % int'(N));
            if (req[pos]) begin
                found_c = 1'b1;
                idx_c   = pos;
            end
        end
        onehot_c = found_c ? (N'(1) << idx_c) : '0;
    end

endmodule : pri_find

// File: rtl/pri_arb.sv
// Fixed-priority / round-robin arbiter holding one grant until the grantee signals done.
module pri_arb
    import pri_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_mode,
    input  logic         i_done,
    output logic         o_busy,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_gidx,
    output logic         o_found
);

    localparam logic [W-1:0] TOP_IDX = W'(N - 1);

    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] start_c;
    logic         hit_c;
    logic [N-1:0] hit_onehot_c;
    logic [W-1:0] hit_idx_c;

    // Round-robin starts just below the last grantee; ptr = 0 wraps to the top.
    always_comb begin
        start_c = TOP_IDX;
        if (i_mode == MODE_RR && ptr != '0) begin
            start_c = ptr - W'(1);
        end
    end

    pri_find #(
        .N (N),
        .W (W)
    ) u_find (
        .req      (i_req),
        .start    (start_c),
        .found_c  (hit_c),
        .onehot_c (hit_onehot_c),
        .idx_c    (hit_idx_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            o_busy  <= 1'b0;
            o_grant <= '0;
            o_gidx  <= '0;
            o_found <= 1'b0;
        end else begin
            o_found <= |i_req;
            unique case (state)
                IDLE: begin
                    if (hit_c) begin
                        state   <= GRANT;
                        ptr     <= hit_idx_c;
                        o_busy  <= 1'b1;
                        o_grant <= hit_onehot_c;
                        o_gidx  <= hit_idx_c;
                    end
                end
                GRANT: begin
                    if (i_done) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_grant <= '0;
                        o_gidx  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : pri_arb

// File: tb/tb_pri_arb.sv
// Randomized and directed bench for pri_arb (N = 8) against a behavioural arbitration model.
module tb_pri_arb;

    localparam int N = 8;
    localparam int W = 3;

    logic         i_clk;
    logic         i_rst;
    logic [N-1:0] i_req;
    logic         i_mode;
    logic         i_done;
    logic         o_busy;
    logic [N-1:0] o_grant;
    logic [W-1:0] o_gidx;
    logic         o_found;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    bit m_found;

    pri_arb #(
        .N (N),
        .W (W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_mode  (i_mode),
        .i_done  (i_done),
        .o_busy  (o_busy),
        .o_grant (o_grant),
        .o_gidx  (o_gidx),
        .o_found (o_found)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Priority order as a list: start index first, then downward with wrap.
    function automatic int pick(input logic [N-1:0] req, input bit rr, input int ptr);
        int order[$];
        int start;
        start = rr ? (ptr + N - 1) % N : N - 1;
        for (int d = 0; d < N; d++) order.push_back((start - d + N) % N);
        foreach (order[i]) if (req[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (i_rst) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_found = 0;
            return;
        end
        m_found = (i_req != '0);
        if (!m_busy) begin
            w = pick(i_req, i_mode, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_idx = w; m_ptr = w;
            end
        end else if (i_done) begin
            m_busy = 0; m_idx = 0;
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] eg;
        eg = m_busy ? (N'(1) << m_idx) : '0;
        check("grant", 64'(o_grant), 64'(eg));
        check("gidx",  64'(o_gidx),  64'(m_busy ? m_idx : 0));
        check("busy",  64'(o_busy),  64'(m_busy));
        check("found", 64'(o_found), 64'(m_found));
        check("onehot0", 64'($onehot0(o_grant)), 64'(1));
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        compare_model();
    endtask

    initial begin
        i_rst = 1'b1; i_req = '0; i_mode = 1'b0; i_done = 1'b0;
        m_busy = 0; m_idx = 0; m_ptr = 0; m_found = 0;
        tick(); tick();
        check("rst_grant", 64'(o_grant), 64'(0));
        check("rst_busy",  64'(o_busy),  64'(0));

        // Fixed priority: highest index wins
        i_rst = 1'b0; i_req = 8'b0010_1001;
        tick();
        check("fixed_grant", 64'(o_grant), 64'h20);
        check("fixed_gidx",  64'(o_gidx),  64'd5);
        i_done = 1'b1; tick();
        i_done = 1'b0; i_req = '0; tick();

        // Round-robin sequence from a fresh pointer
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        i_mode = 1'b1; i_req = 8'b1000_0011;
        begin
            int exp_seq[4] = '{7, 1, 0, 7};
            foreach (exp_seq[i]) begin
                tick();
                check("rr_seq", 64'(o_gidx), 64'(exp_seq[i]));
                i_done = 1'b1; tick();
                check("rr_idle", 64'(o_busy), 64'(0));
                i_done = 1'b0;
            end
        end

        // Hold while requests change and done stays low
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        i_mode = 1'b0; i_req = 8'b0000_1000;
        tick();
        check("hold_first", 64'(o_gidx), 64'd3);
        i_req = 8'b1000_0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_gidx", 64'(o_gidx), 64'd3);
        end
        i_done = 1'b1; tick();
        check("hold_release", 64'(o_grant), 64'(0));
        i_done = 1'b0; tick();
        check("hold_next", 64'(o_gidx), 64'd7);

        // Reset mid-grant takes priority over done
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        i_req = 8'b0100_0000; tick();
        check("mid_gidx", 64'(o_gidx), 64'd6);
        i_rst = 1'b1; i_done = 1'b1; tick();
        check("mid_rst_grant", 64'(o_grant), 64'(0));
        check("mid_rst_found", 64'(o_found), 64'(0));
        i_rst = 1'b0; i_done = 1'b0; i_mode = 1'b1; i_req = 8'hFF;
        tick();
        check("post_rst_rr", 64'(o_gidx), 64'd7);

        // Mode change during a held grant affects only the next arbitration
        i_req = 8'b1000_0011; i_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mode_hold", 64'(o_gidx), 64'd7);
        end
        i_done = 1'b1; tick();
        i_done = 1'b0; tick();
        check("mode_fixed_next", 64'(o_gidx), 64'd7);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            i_rst  = ($urandom_range(0, 199) == 0);
            i_mode = 1'($urandom_range(0, 1));
            i_done = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       i_req = '0;
                1:       i_req = N'(1) << $urandom_range(0, N - 1);
                default: i_req = N'($urandom);
            endcase
            tick();
            if (o_busy) check("rand_gidx_enc", 64'(o_grant), 64'(N'(1) << o_gidx));
            else        check("rand_gidx_zero", 64'(o_gidx), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pri_arb
